// File: rtl/irq_pending_ctrl_8.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_ctrl_8
// Purpose  : Eight-line interrupt front end. Captures request events into a
//            pending register, picks the highest-numbered eligible request and
//            presents its 3-bit index with a valid/ack handshake. The
//            presented index is held until the consumer acknowledges it.
//
// Parameters
//   LEVEL_MODE  0 = rising-edge capture, 1 = level capture
//
// Build option
//   IRQ_MASK_EN defined   : 8-bit mask register (1 = disabled) with the
//                           mask_wr / mask_in ports present
//   IRQ_MASK_EN undefined : no mask, every pending bit is eligible
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   irq_in     in   [7:0] request lines, synchronous to clk, bit 7 highest
//   irq_ack    in   consumer accepts the presented index (valid only)
//   mask_wr    in   load mask_in into the mask register (IRQ_MASK_EN only)
//   mask_in    in   [7:0] new mask value (IRQ_MASK_EN only)
//   irq_valid  out  an index is being presented
//   irq_id     out  [2:0] presented index, stable while irq_valid = 1
//   pending    out  [7:0] pending register, masked bits included
//
// Revision : 1.0  initial release
// ============================================================================
module irq_pending_ctrl_8 #(
  parameter int LEVEL_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       irq_ack,
`ifdef IRQ_MASK_EN
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
`endif
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] irq_id_q;
  logic [2:0] irq_id_d;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] irq_q;
  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [2:0] top_idx;

  // --------------------------------------------------------------------------
  // Input stage: previous-cycle copy of the request lines for edge detection.
  // Resetting it to zero makes a line that is already high at reset release
  // look like a rising edge on the first clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 8'h00;
    end else begin
      irq_q <= irq_in;
    end
  end

  generate
    if (LEVEL_MODE != 0) begin : g_level
      assign set = irq_in;
    end else begin : g_edge
      assign set = irq_in & ~irq_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Mask and eligibility
  // --------------------------------------------------------------------------
`ifdef IRQ_MASK_EN
  logic [7:0] mask_q;
  logic [7:0] mask_d;

  always_comb begin
    mask_d = mask_q;
    if (mask_wr) begin
      mask_d = mask_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 8'h00;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign elig = pending_q & ~mask_q;
`else
  assign elig = pending_q;
`endif

  // --------------------------------------------------------------------------
  // Highest set bit of the eligible vector. The ascending scan lets the
  // highest-numbered set bit overwrite any lower one.
  // --------------------------------------------------------------------------
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) begin
        top_idx = i[2:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending update. The clear only exists while an index is actually being
  // presented and acknowledged; an ack in IDLE clears nothing. A new event
  // on the bit being cleared in the same cycle wins, so it is not lost.
  // --------------------------------------------------------------------------
  always_comb begin
    clr = 8'h00;
    if ((state_q == ST_PRESENT) && irq_ack) begin
      clr = 8'h01 << irq_id_q;
    end
  end

  always_comb begin
    pending_d = (pending_q & ~clr) | set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 8'h00;
    end else begin
      pending_q <= pending_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant FSM. Once in PRESENT the index is frozen: new arrivals, mask
  // writes and pending changes are ignored until the ack is seen.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (elig != 8'h00) begin
          state_d  = ST_PRESENT;
          irq_id_d = top_idx;
        end
      end
      ST_PRESENT: begin
        if (irq_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      irq_id_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registers only.
  // --------------------------------------------------------------------------
  assign irq_valid = (state_q == ST_PRESENT);
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_ctrl_8
// Purpose  : Self-checking bench for irq_pending_ctrl_8 (edge mode). A table
//            of per-cycle {inputs, expected outputs} records is applied one
//            clock at a time, followed by hand-written sequences for
//            asynchronous reset mid-handshake and, when IRQ_MASK_EN is
//            defined, the mask behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_pending_ctrl_8;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
`ifdef IRQ_MASK_EN
  logic       mask_wr;
  logic [7:0] mask_in;
`endif

  int n_tests;
  int n_fail;

  irq_pending_ctrl_8 #(
    .LEVEL_MODE(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .irq_ack  (irq_ack),
`ifdef IRQ_MASK_EN
    .mask_wr  (mask_wr),
    .mask_in  (mask_in),
`endif
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq_in;
    logic       ack;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [7:0] exp_pend;
  } vec_t;

  localparam int NVEC = 35;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic [7:0] in_v, input logic ack_v);
    irq_in  = in_v;
    irq_ack = ack_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [2:0] id,
                           input logic [7:0] p);
    check({name, ".valid"}, {7'd0, irq_valid}, {7'd0, v});
    if (v) check({name, ".id"}, {5'd0, irq_id}, {5'd0, id});
    check({name, ".pending"}, pending, p);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // idx: irq_in, ack, exp_valid, exp_id, exp_pending
    // single pulse on bit 2
    vecs[0]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    vecs[1]  = '{8'h04, 1'b0, 1'b0, 3'd0, 8'h04};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 3'd2, 8'h04};
    vecs[3]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    // simultaneous bits 1,5,6 -> grants 6,5,1 with one idle cycle between
    vecs[5]  = '{8'h62, 1'b0, 1'b0, 3'd0, 8'h62};
    vecs[6]  = '{8'h62, 1'b0, 1'b1, 3'd6, 8'h62};
    vecs[7]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h22};
    vecs[8]  = '{8'h00, 1'b0, 1'b1, 3'd5, 8'h22};
    vecs[9]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h02};
    vecs[10] = '{8'h00, 1'b0, 1'b1, 3'd1, 8'h02};
    vecs[11] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    // presenting 3 while bit 7 arrives: id stays 3, then 7
    vecs[13] = '{8'h08, 1'b0, 1'b0, 3'd0, 8'h08};
    vecs[14] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h08};
    vecs[15] = '{8'h80, 1'b0, 1'b1, 3'd3, 8'h88};
    vecs[16] = '{8'h80, 1'b0, 1'b1, 3'd3, 8'h88};
    vecs[17] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h80};
    vecs[18] = '{8'h00, 1'b0, 1'b1, 3'd7, 8'h80};
    vecs[19] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    // ack colliding with a new edge on bit 4: set wins, re-granted
    vecs[20] = '{8'h10, 1'b0, 1'b0, 3'd0, 8'h10};
    vecs[21] = '{8'h00, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[22] = '{8'h10, 1'b1, 1'b0, 3'd0, 8'h10};
    vecs[23] = '{8'h00, 1'b0, 1'b1, 3'd4, 8'h10};
    vecs[24] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    // ack in IDLE is ignored
    vecs[25] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[26] = '{8'h20, 1'b1, 1'b0, 3'd0, 8'h20};
    vecs[27] = '{8'h00, 1'b1, 1'b1, 3'd5, 8'h20};
    vecs[28] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[29] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};
    // repeated edge on an already-pending bit is absorbed
    vecs[30] = '{8'h01, 1'b0, 1'b0, 3'd0, 8'h01};
    vecs[31] = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01};
    vecs[32] = '{8'h01, 1'b0, 1'b1, 3'd0, 8'h01};
    vecs[33] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[34] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00};

    // ---------------- reset state ----------------
    rst     = 1'b1;
    irq_in  = 8'h00;
    irq_ack = 1'b0;
`ifdef IRQ_MASK_EN
    mask_wr = 1'b0;
    mask_in = 8'h00;
`endif
    #12;
    check("reset.valid",   {7'd0, irq_valid}, 8'h00);
    check("reset.id",      {5'd0, irq_id},    8'h00);
    check("reset.pending", pending,           8'h00);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].irq_in, vecs[i].ack);
      check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_id,
                vecs[i].exp_pend);
    end

    // ---------------- async reset mid-handshake ----------------
    step(8'h40, 1'b0);
    step(8'h00, 1'b0);
    check_out("pre_rst", 1'b1, 3'd6, 8'h40);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.valid",   {7'd0, irq_valid}, 8'h00);
    check("async_rst.id",      {5'd0, irq_id},    8'h00);
    check("async_rst.pending", pending,           8'h00);
    // line already high at release counts as a rising edge
    irq_in = 8'h40;
    @(negedge clk);
    rst = 1'b0;
    step(8'h40, 1'b0);
    check_out("rel_high.pend", 1'b0, 3'd0, 8'h40);
    step(8'h00, 1'b0);
    check_out("rel_high.grant", 1'b1, 3'd6, 8'h40);
    step(8'h00, 1'b1);
    check_out("rel_high.ack", 1'b0, 3'd0, 8'h00);

`ifdef IRQ_MASK_EN
    // ---------------- mask behaviour ----------------
    mask_wr = 1'b1;
    mask_in = 8'h80;
    step(8'h81, 1'b0);
    mask_wr = 1'b0;
    check_out("mask.pend", 1'b0, 3'd0, 8'h81);
    step(8'h00, 1'b0);
    check_out("mask.grant0", 1'b1, 3'd0, 8'h81);
    step(8'h00, 1'b1);
    check_out("mask.ack0", 1'b0, 3'd0, 8'h80);
    step(8'h00, 1'b0);
    check_out("mask.held7", 1'b0, 3'd0, 8'h80);
    mask_wr = 1'b1;
    mask_in = 8'h00;
    step(8'h00, 1'b0);
    mask_wr = 1'b0;
    check_out("mask.unmask", 1'b0, 3'd0, 8'h80);
    step(8'h00, 1'b0);
    check_out("mask.grant7", 1'b1, 3'd7, 8'h80);
    step(8'h00, 1'b1);
    check_out("mask.ack7", 1'b0, 3'd0, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
